// File: rtl/imem_loader_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | imem_loader_pkg: shared loader states, NOP encoding, default geometry    |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam logic [31:0] NOP           = 32'h0000_0000;
    localparam int          DEFAULT_DEPTH = 256;
    localparam int          DEFAULT_AW    = 8;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | imem_array: instruction storage, one sync write port, one comb read port |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module imem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] r_mem [DEPTH];

    // No reset: contents survive reset and reloads until overwritten.
    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : imem_array
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | imem_loader: byte-stream program loader feeding a core fetch port        |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        core_hold,
    output logic        load_done,
    output logic        load_error
);

    if (DEPTH != 2 ** AW) begin : g_bad_depth
        $error("imem_loader: DEPTH must equal 2**AW");
    end

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_bcnt;
    logic [15:0]   r_n;
    logic [23:0]   r_shift;

    logic          w_fire;
    logic          w_we;
    logic          w_last;
    logic [15:0]   w_count;
    logic [31:0]   w_word;
    logic [31:0]   w_rdata;
    logic          w_unused_pc;

    assign w_fire  = byte_valid & byte_ready;
    assign w_count = {r_n[15:8], byte_data};
    assign w_word  = {r_shift, byte_data};
    assign w_we    = w_fire && (r_state == S_DATA) && (r_bcnt == 2'd3) && !reset;
    // Compared one bit wider than the address so N == DEPTH terminates cleanly.
    assign w_last  = (({{(17 - AW){1'b0}}, r_addr} + 17'd1) == {1'b0, r_n});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_bcnt     <= 2'd0;
            r_n        <= 16'd0;
            r_shift    <= 24'd0;
            byte_ready <= 1'b0;
            core_hold  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_state    <= S_COUNT;
                        r_addr     <= '0;
                        r_bcnt     <= 2'd0;
                        r_n        <= 16'd0;
                        byte_ready <= 1'b1;
                        core_hold  <= 1'b1;
                        load_done  <= 1'b0;
                        load_error <= 1'b0;
                    end
                end
                S_COUNT: begin
                    if (w_fire) begin
                        if (r_bcnt == 2'd0) begin
                            r_n[15:8] <= byte_data;
                            r_bcnt    <= 2'd1;
                        end else begin
                            r_n    <= w_count;
                            r_bcnt <= 2'd0;
                            if (w_count == 16'd0) begin
                                r_state    <= S_DONE;
                                byte_ready <= 1'b0;
                                core_hold  <= 1'b0;
                                load_done  <= 1'b1;
                            end else if ({1'b0, w_count} > 17'(DEPTH)) begin
                                r_state    <= S_ERROR;
                                byte_ready <= 1'b0;
                                load_error <= 1'b1;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (w_fire) begin
                        r_bcnt  <= r_bcnt + 2'd1;
                        r_shift <= {r_shift[15:0], byte_data};
                        if (r_bcnt == 2'd3) begin
                            r_addr <= r_addr + 1'b1;
                            if (w_last) begin
                                r_state    <= S_DONE;
                                byte_ready <= 1'b0;
                                core_hold  <= 1'b0;
                                load_done  <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    byte_ready <= 1'b0;
                    core_hold  <= 1'b1;
                    load_done  <= 1'b0;
                    load_error <= 1'b0;
                end
            endcase
        end
    end

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clock (clock),
        .we    (w_we),
        .waddr (r_addr),
        .wdata (w_word),
        .raddr (pc[AW-1:0]),
        .rdata (w_rdata)
    );

    // Upper PC bits are intentionally ignored: the memory aliases.
    assign w_unused_pc = ^pc[31:AW];
    assign instruction = core_hold ? NOP : w_rdata;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_imem_loader: directed, scoreboard-checked bench for imem_loader       |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        clock      = 1'b0;
    logic        reset      = 1'b1;
    logic        start      = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data  = 8'h00;
    logic [31:0] pc         = 32'h0;
    logic        byte_ready;
    logic [31:0] instruction;
    logic        core_hold;
    logic        load_done;
    logic        load_error;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] stim_words[$];
    logic [31:0] exp_mem [256];
    int          errors = 0;
    int          checks = 0;

    imem_loader #(
        .DEPTH (256),
        .AW    (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .pc          (pc),
        .instruction (instruction),
        .core_hold   (core_hold),
        .load_done   (load_done),
        .load_error  (load_error)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waited;
        bit accepted;
        if (gaps) begin
            byte_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        byte_valid = 1'b1;
        byte_data  = b;
        waited     = 0;
        accepted   = 1'b0;
        while (!accepted && waited < 40) begin
            accepted = byte_ready;
            tick();
            waited++;
        end
        if (!accepted) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        byte_valid = 1'b0;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic load(input logic [15:0] n, input bit gaps, input int start_at);
        logic [31:0] w;
        send_byte(n[15:8], gaps);
        send_byte(n[7:0], gaps);
        for (int i = 0; i < stim_words.size(); i++) begin
            w = stim_words[i];
            if (i == start_at) begin
                pulse_start();
                check("mid_start_ready", {31'd0, byte_ready}, 32'd1);
                check("mid_start_done", {31'd0, load_done}, 32'd0);
            end
            sb.push_back('{i, w});
            exp_mem[i] = w;
            for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gaps);
        end
        byte_valid = 1'b0;
    endtask

    task automatic drain();
        sb_t e;
        while (sb.size() > 0) begin
            e  = sb.pop_front();
            pc = 32'(e.addr);
            #1;
            check($sformatf("read_mem%0d", e.addr), instruction, e.data);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("rst_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_hold", {31'd0, core_hold}, 32'd1);
        check("rst_done", {31'd0, load_done}, 32'd0);
        check("rst_error", {31'd0, load_error}, 32'd0);
        check("rst_instr", instruction, NOP);

        // Two-word program
        pulse_start();
        check("count_ready", {31'd0, byte_ready}, 32'd1);
        stim_words = '{32'h2008_0005, 32'h0109_5020};
        load(16'd2, 1'b0, -1);
        check("p2_done", {31'd0, load_done}, 32'd1);
        check("p2_hold", {31'd0, core_hold}, 32'd0);
        check("p2_ready", {31'd0, byte_ready}, 32'd0);
        pc = 32'd1;
        #1;
        check("p2_pc1", instruction, 32'h0109_5020);
        drain();

        // Empty program: DONE two edges after entering COUNT
        pulse_start();
        check("n0_ready", {31'd0, byte_ready}, 32'd1);
        check("n0_done_cleared", {31'd0, load_done}, 32'd0);
        send_byte(8'h00, 1'b0);
        check("n0_mid_done", {31'd0, load_done}, 32'd0);
        send_byte(8'h00, 1'b0);
        byte_valid = 1'b0;
        check("n0_done", {31'd0, load_done}, 32'd1);
        pc = 32'd0;
        #1;
        check("n0_mem0_kept", instruction, exp_mem[0]);

        // Oversized header -> ERROR, then recovery
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        byte_valid = 1'b0;
        check("err_flag", {31'd0, load_error}, 32'd1);
        check("err_hold", {31'd0, core_hold}, 32'd1);
        check("err_ready", {31'd0, byte_ready}, 32'd0);
        check("err_instr", instruction, NOP);
        pulse_start();
        check("err_recover_ready", {31'd0, byte_ready}, 32'd1);
        check("err_recover_flag", {31'd0, load_error}, 32'd0);

        // Three words with random stalls and an ignored mid-DATA start
        stim_words = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D};
        load(16'd3, 1'b1, 1);
        check("gap_done", {31'd0, load_done}, 32'd1);
        drain();

        // Reset after 6 of 8 data bytes
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        exp_mem[0] = 32'hA1B2_C3D4;
        send_byte(8'hA1, 1'b0);
        send_byte(8'hB2, 1'b0);
        send_byte(8'hC3, 1'b0);
        send_byte(8'hD4, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        byte_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pc = 32'd0;
        #1;
        check("mrst_ready", {31'd0, byte_ready}, 32'd0);
        check("mrst_hold", {31'd0, core_hold}, 32'd1);
        check("mrst_instr", instruction, NOP);
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        byte_valid = 1'b0;
        pc = 32'd0;
        #1;
        check("mrst_mem0", instruction, exp_mem[0]);
        pc = 32'd1;
        #1;
        check("mrst_mem1_kept", instruction, exp_mem[1]);

        // Full-depth load
        stim_words.delete();
        for (int i = 0; i < 256; i++) stim_words.push_back($urandom());
        pulse_start();
        load(16'd256, 1'b0, -1);
        check("full_done", {31'd0, load_done}, 32'd1);
        check("full_ready", {31'd0, byte_ready}, 32'd0);
        drain();
        pc = 32'h0000_0100;
        #1;
        check("full_alias_0", instruction, exp_mem[0]);
        pc = 32'h0000_01FF;
        #1;
        check("full_alias_255", instruction, exp_mem[255]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit instruction words held.
REQ-002 Parameter AW, default 8, word-address width; DEPTH SHALL equal 2**AW.
REQ-003 clock  in  1  single clock, all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to begin a program load.
REQ-006 byte_valid  in  1  loader-stream byte present.
REQ-007 byte_data  in  8  loader-stream byte.
REQ-008 byte_ready  out  1  block accepts byte this cycle.
REQ-009 pc  in  32  core program counter, word-indexed (PC+1 = next instruction).
REQ-010 instruction  out  32  instruction word for the core fetch.
REQ-011 core_hold  out  1  core SHALL NOT advance PC while high.
REQ-012 load_done  out  1  level, program loaded and core released.
REQ-013 load_error  out  1  level, header word count exceeded DEPTH.

Function
REQ-014 States SHALL be IDLE, COUNT, DATA, DONE, ERROR.
REQ-015 A byte transfer SHALL occur only on a rising edge where byte_valid and byte_ready are both 1.
REQ-016 byte_ready SHALL be 1 in COUNT and DATA, 0 in all other states; it SHALL NOT depend on byte_valid.
REQ-017 IDLE: start=1 -> COUNT; word address and byte counters cleared to 0.
REQ-018 COUNT: two bytes form 16-bit word count N, first byte = N[15:8]; after the second byte: N=0 -> DONE, N>DEPTH -> ERROR, else -> DATA.
REQ-019 DATA: bytes assemble big-endian (first byte -> bits 31:24); on acceptance of the 4th byte the word SHALL be written to mem[addr] in that same edge and addr SHALL increment.
REQ-020 After the N-th word write the state SHALL go to DONE in the same edge; no further bytes accepted.
REQ-021 N=DEPTH SHALL be legal; addr wrap-around SHALL NOT occur because the load terminates at N.
REQ-022 A written word SHALL be visible on instruction from the cycle after its write edge.
REQ-023 instruction SHALL be mem[pc[AW-1:0]] combinationally while core_hold=0; pc bits above AW-1 ignored.
REQ-024 instruction SHALL be 32'h00000000 (NOP) while core_hold=1.
REQ-025 core_hold SHALL be 1 in IDLE, COUNT, DATA, ERROR and 0 only in DONE.
REQ-026 load_done SHALL be 1 only in DONE; load_error SHALL be 1 only in ERROR.
REQ-027 start in COUNT or DATA SHALL be ignored.
REQ-028 start in DONE or ERROR SHALL go to COUNT, clearing counters and flags; memory contents retained until overwritten.
REQ-029 byte_valid with byte_ready=0 SHALL have no effect; a byte is not lost, the source holds it.

Reset
REQ-030 reset SHALL force state IDLE, addr/byte counters/N to 0, byte_ready=0, core_hold=1, load_done=0, load_error=0.
REQ-031 reset SHALL take priority over start and byte transfers in the same edge.
REQ-032 reset mid-load SHALL discard the partial word; words already written SHALL be retained; memory array SHALL NOT be cleared by reset.

Structure
REQ-033 A shared package SHALL hold the state enumeration, NOP encoding (32'h0) and default DEPTH/AW constants.
REQ-034 The storage SHALL be a sub-module imem_array: one synchronous write port, one combinational read port.
REQ-035 The FSM, counters and byte assembler SHALL live in imem_loader.

Verification
REQ-036 Reset, start, bytes 00 02 | 20 08 00 05 | 01 09 50 20 -> mem[0]=0x20080005, mem[1]=0x01095020, DONE, core_hold=0, pc=1 gives 0x01095020.
REQ-037 Header 00 00 -> DONE two edges after COUNT entry, no memory writes, load_done=1.
REQ-038 Header 01 01 (N=257 > 256) -> ERROR, load_error=1, core_hold=1, byte_ready=0; start then recovers to COUNT.
REQ-039 byte_valid toggled randomly during 3-word load -> identical memory image to back-to-back stream; start pulsed mid-DATA ignored.
REQ-040 reset after 6 of 8 data bytes of N=2 -> mem[0] written, mem[1] unchanged, IDLE, instruction=0.
REQ-041 N=256 full load -> mem[255] written, DONE; pc=0x00000100 reads mem[0].
